// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle arithmetic/logic/branch ops plus iterative CLO/CLZ.
// Define MULTICYCLE_ALU_FAST_COUNT_EN to compute CLO/CLZ in one edge with a priority encoder.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned IW = $clog2(WIDTH);

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnClz  = 6'b000111;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;
  localparam logic [5:0] FnBgtz = 6'b110010;
  localparam logic [5:0] FnB    = 6'b110100;
  localparam logic [5:0] FnBlez = 6'b110110;
  localparam logic [5:0] FnClo  = 6'b111000;

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] sum, diff, op_res;
  logic             op_ovf, op_ill, op_tgt, accept;

`ifdef MULTICYCLE_ALU_FAST_COUNT_EN
  function automatic logic [CW-1:0] lead_count(input logic [WIDTH-1:0] v, input logic tgt);
    logic [CW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (run && (v[i] == tgt)) n = n + CW'(1);
      else                      run = 1'b0;
    end
    return n;
  endfunction
`else
  logic             op_iter;
  logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic             tgt_q, tgt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             bit_hit;
`endif

  assign sum  = a + b;
  assign diff = a - b;

  // Function decode for everything that completes on the accepting edge.
  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    op_ill = 1'b0;
    op_tgt = 1'b0;
`ifndef MULTICYCLE_ALU_FAST_COUNT_EN
    op_iter = 1'b0;
`endif
    case (func)
      FnAdd: begin
        op_res = sum;
        op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      FnSub: begin
        op_res = diff;
        op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      FnAnd:  op_res = a & b;
      FnOr:   op_res = a | b;
      FnXor:  op_res = a ^ b;
      FnNor:  op_res = ~(a | b);
      FnSlt:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      FnSltu: op_res = {{(WIDTH-1){1'b0}}, (a < b)};
      FnSll:  op_res = b << shamt;
      FnSrl:  op_res = b >> shamt;
      FnSra:  op_res = $unsigned($signed(b) >>> shamt);
      FnBgtz: op_res = {{(WIDTH-1){1'b0}}, (!a[WIDTH-1] && (a != '0))};
      FnB:    op_res = {{(WIDTH-1){1'b0}}, 1'b1};
      FnBlez: op_res = {{(WIDTH-1){1'b0}}, (a[WIDTH-1] || (a == '0))};
      FnClo, FnClz: begin
        op_tgt = (func == FnClo);
`ifdef MULTICYCLE_ALU_FAST_COUNT_EN
        op_res = WIDTH'(lead_count(a, op_tgt));
`else
        op_iter = 1'b1;
`endif
      end
      default: op_ill = 1'b1;
    endcase
  end

  assign accept = start && (state_q != StCount);

`ifndef MULTICYCLE_ALU_FAST_COUNT_EN
  assign bit_hit = (cnt_a_q[idx_q] == tgt_q);
  assign cnt_inc = cnt_q + CW'(bit_hit);
`endif

  always_comb begin
    state_d  = StIdle;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
`ifndef MULTICYCLE_ALU_FAST_COUNT_EN
    cnt_a_d  = cnt_a_q;
    tgt_d    = tgt_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
`ifndef MULTICYCLE_ALU_FAST_COUNT_EN
          if (op_iter) begin
            state_d = StCount;
            cnt_a_d = a;
            tgt_d   = op_tgt;
            idx_d   = IW'(WIDTH - 1);
            cnt_d   = '0;
          end else
`endif
          begin
            state_d  = StDone;
            result_d = op_res;
            zero_d   = (op_res == '0);
            ovf_d    = op_ovf;
            ill_d    = op_ill;
          end
        end
      end
`ifndef MULTICYCLE_ALU_FAST_COUNT_EN
      StCount: begin
        // Stop on the first non-matching bit or once bit 0 has been examined.
        if (!bit_hit || (idx_q == '0)) begin
          state_d  = StDone;
          result_d = WIDTH'(cnt_inc);
          zero_d   = (cnt_inc == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
        end else begin
          state_d = StCount;
          cnt_d   = cnt_inc;
          idx_d   = idx_q - IW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

`ifndef MULTICYCLE_ALU_FAST_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      tgt_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      tgt_q   <= tgt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StCount);
`else
  assign busy = 1'b0;
`endif

  assign done     = (state_q == StDone);
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed vectors push expectations, a negedge monitor
// pops and checks result, flags, latency and busy cycles on every done pulse.
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   func = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   shamt = '0;
  logic         busy, done, zero, overflow, illegal;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         i;
    int           cyc;
    int           bsy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  int   n_done = 0;
  int   n_issued = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .a(a), .b(b), .shamt(shamt),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow),
    .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int it_lat(input int l);
`ifdef MULTICYCLE_ALU_FAST_COUNT_EN
    return 1;
`else
    return l;
`endif
  endfunction

  // Called aligned to posedge+1; returns aligned to posedge+1 after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [4:0] sh, input logic [W-1:0] r, input logic o,
                       input logic il, input int lat);
    exp_t e;
    start = 1'b1; func = f; a = aa; b = bb; shamt = sh;
    e.res = r; e.z = (r == '0); e.o = o; e.i = il; e.cyc = cyc + lat; e.bsy = lat - 1;
    sb.push_back(e);
    n_issued++;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; shamt = 5'($urandom); func = 6'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", 64'(sb.size()), 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_timeout", 64'(done), 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("result", 64'(result), 64'(mon_e.res));
          check("flags_zov_ill", 64'({zero, overflow, illegal}),
                64'({mon_e.z, mon_e.o, mon_e.i}));
          check("latency", 64'(cyc), 64'(mon_e.cyc));
          check("busy_cycles", 64'(busy_cnt), 64'(mon_e.bsy));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #12;
    check("reset_ctrl_flags", 64'({busy, done, zero, overflow, illegal}), 0);
    check("reset_result", 64'(result), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops, issued back-to-back (each accepted while the previous is in DONE).
    issue(6'b100000, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b1, 1'b0, 1);
    issue(6'b100010, 32'h5,         32'h5,         5'd0,  32'h0,         1'b0, 1'b0, 1);
    issue(6'b100010, 32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    issue(6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  32'h00F0_1234, 1'b0, 1'b0, 1);
    issue(6'b100101, 32'h0000_00F0, 32'h0000_000F, 5'd0,  32'h0000_00FF, 1'b0, 1'b0, 1);
    issue(6'b100110, 32'hFFFF_0000, 32'hFF00_FF00, 5'd0,  32'h00FF_FF00, 1'b0, 1'b0, 1);
    issue(6'b100111, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    issue(6'b101010, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         1'b0, 1'b0, 1);
    issue(6'b101011, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b0, 1'b0, 1);
    issue(6'b000000, 32'h0,         32'h1,         5'd31, 32'h8000_0000, 1'b0, 1'b0, 1);
    issue(6'b000010, 32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0, 1);
    issue(6'b000011, 32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0, 1);
    issue(6'b110010, 32'h0,         32'h0,         5'd0,  32'h0,         1'b0, 1'b0, 1);
    issue(6'b110010, 32'h1,         32'h0,         5'd0,  32'h1,         1'b0, 1'b0, 1);
    issue(6'b110110, 32'hFFFF_FFFF, 32'h0,         5'd0,  32'h1,         1'b0, 1'b0, 1);
    issue(6'b110100, 32'h0,         32'h0,         5'd0,  32'h1,         1'b0, 1'b0, 1);
    issue(6'b111111, 32'h1234,      32'h5678,      5'd0,  32'h0,         1'b0, 1'b1, 1);
    wait_idle();

    issue(6'b000111, 32'h0001_0000, 32'h0, 5'd0, 32'd15, 1'b0, 1'b0, it_lat(17));
    wait_idle();

    // CLO of all ones with a stray ADD start mid-count, then an ADD accepted in DONE.
    issue(6'b111000, 32'hFFFF_FFFF, 32'h0, 5'd0, 32'd32, 1'b0, 1'b0, it_lat(33));
`ifndef MULTICYCLE_ALU_FAST_COUNT_EN
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; func = 6'b100000; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_mid_count", 64'(busy), 1);
`endif
    wait_done();
    issue(6'b100000, 32'h2, 32'h3, 5'd0, 32'h5, 1'b0, 1'b0, 1);
    wait_idle();

    issue(6'b000111, 32'h8000_0000, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, it_lat(2));
    wait_idle();

`ifndef MULTICYCLE_ALU_FAST_COUNT_EN
    // Abort a long CLZ with reset; outputs must clear at once and no done may follow.
    issue(6'b110010, 32'h1, 32'h0, 5'd0, 32'h1, 1'b0, 1'b0, 1);
    wait_idle();
    start = 1'b1; func = 6'b000111; a = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_before_abort", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl_flags", 64'({busy, done, zero, overflow, illegal}), 0);
    check("abort_result", 64'(result), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
`endif
    check("done_count", 64'(n_done), 64'(n_issued));
    check("scoreboard_empty", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
